// File: rtl/mem_stack_responder.sv
// Single-port request responder over two independent word memories (data and stack).
// Each accepted request walks IDLE -> [RD] -> [WR] -> DONE and pulses resp_valid once.
module mem_stack_responder #(
  parameter int MEM_DEPTH = 256,
  parameter int STK_DEPTH = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_stack,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_error
);

  localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int SAW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam logic [16:0] MEM_LIM = 17'(MEM_DEPTH);
  localparam logic [16:0] STK_LIM = 17'(STK_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [15:0] cap_addr;
  logic [15:0] cap_wdata;
  logic        cap_write;
  logic        cap_stack;
  logic        accept;
  logic        in_range;
  logic [15:0] rd_word;

  logic [15:0] data_mem [MEM_DEPTH];
  logic [15:0] stk_mem  [STK_DEPTH];

  assign accept = (state == IDLE) && req_valid && (req_read || req_write);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = req_read ? RD : WR;
      end
      RD:      next_state = cap_write ? WR : DONE;
      WR:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_addr  <= 16'h0000;
      cap_wdata <= 16'h0000;
      cap_write <= 1'b0;
      cap_stack <= 1'b0;
    end else if (accept) begin
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_write <= req_write;
      cap_stack <= req_stack;
    end
  end

  // Range check is against the full 16-bit address so nothing ever wraps.
  always_comb begin
    if (cap_stack) in_range = ({1'b0, cap_addr} < STK_LIM);
    else           in_range = ({1'b0, cap_addr} < MEM_LIM);
  end

  always_comb begin
    rd_word = 16'h0000;
    if (in_range) begin
      if (cap_stack) rd_word = stk_mem[cap_addr[SAW-1:0]];
      else           rd_word = data_mem[cap_addr[MAW-1:0]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              resp_rdata <= 16'h0000;
    else if (state == RD)   resp_rdata <= rd_word;
  end

  // Memories are never cleared; a reset before the WR exit edge leaves state IDLE, so no write.
  always_ff @(posedge clock) begin
    if (state == WR && in_range) begin
      if (cap_stack) stk_mem[cap_addr[SAW-1:0]]  <= cap_wdata;
      else           data_mem[cap_addr[MAW-1:0]] <= cap_wdata;
    end
  end

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == DONE);
  assign resp_error = (state == DONE) && !in_range;

endmodule

// File: tb/tb_mem_stack_responder.sv
// Directed self-checking bench for mem_stack_responder with hand-computed expectations.
module tb_mem_stack_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic        req_stack = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_error;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stack_responder #(.MEM_DEPTH(256), .STK_DEPTH(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_read   (req_read),
    .req_write  (req_write),
    .req_stack  (req_stack),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  always #5 clock = ~clock;

  // lat counts the accept edge as edge 1.
  task automatic do_req(input logic rd, input logic wr, input logic stk,
                        input logic [15:0] addr, input logic [15:0] wd,
                        output logic [15:0] rdata, output logic err, output int lat);
    bit got;
    bit rdy;
    rdata = 16'hxxxx;
    err   = 1'bx;
    lat   = 0;
    got   = 0;
    rdy   = 0;
    for (int i = 0; i < 10 && !rdy; i++) begin
      @(negedge clock);
      rdy = req_ready;
    end
    n_cmp++;
    if (!rdy) begin
      n_bad++;
      $display("FAIL ready_wait: req_ready stayed %b, expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_read  = rd;
    req_write = wr;
    req_stack = stk;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clock);
      #1;
      lat++;
      if (resp_valid) begin
        got   = 1;
        rdata = resp_rdata;
        err   = resp_error;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL resp_timeout: resp_valid=%b after %0d edges, expected 1", resp_valid, lat);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL resp_pulse_width: resp_valid=%b, expected 0", resp_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
    n_cmp++;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", resp_valid); end
    n_cmp++;
    if (resp_rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_rdata: got %h expected 0000", resp_rdata); end
    n_cmp++;
    if (resp_error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b expected 0", resp_error); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_data_rw();
    logic [15:0] rd;
    logic er;
    int lt;
    do_req(1'b0, 1'b1, 1'b0, 16'h0005, 16'hBEEF, rd, er, lt);
    n_cmp++;
    if (lt !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d expected 2", lt); end
    n_cmp++;
    if (er !== 1'b0) begin n_bad++; $display("FAIL wr_error: got %b expected 0", er); end
    do_req(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, rd, er, lt);
    n_cmp++;
    if (lt !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d expected 2", lt); end
    n_cmp++;
    if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data: got %h expected beef", rd); end
    n_cmp++;
    if (er !== 1'b0) begin n_bad++; $display("FAIL rd_error: got %b expected 0", er); end
  endtask

  task automatic test_spaces();
    logic [15:0] rd;
    logic er;
    int lt;
    do_req(1'b0, 1'b1, 1'b1, 16'h0005, 16'h1234, rd, er, lt);
    // Write-only response keeps the last read value.
    n_cmp++;
    if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL wr_holds_rdata: got %h expected beef", rd); end
    do_req(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, rd, er, lt);
    n_cmp++;
    if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL data_no_alias: got %h expected beef", rd); end
    do_req(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000, rd, er, lt);
    n_cmp++;
    if (rd !== 16'h1234) begin n_bad++; $display("FAIL stack_read: got %h expected 1234", rd); end
  endtask

  task automatic test_read_write();
    logic [15:0] rd;
    logic er;
    int lt;
    do_req(1'b0, 1'b1, 1'b1, 16'h0003, 16'h00AA, rd, er, lt);
    do_req(1'b1, 1'b1, 1'b1, 16'h0003, 16'h5555, rd, er, lt);
    n_cmp++;
    if (lt !== 3) begin n_bad++; $display("FAIL rw_latency: got %0d expected 3", lt); end
    n_cmp++;
    if (rd !== 16'h00AA) begin n_bad++; $display("FAIL rw_old_data: got %h expected 00aa", rd); end
    n_cmp++;
    if (er !== 1'b0) begin n_bad++; $display("FAIL rw_error: got %b expected 0", er); end
    do_req(1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, rd, er, lt);
    n_cmp++;
    if (rd !== 16'h5555) begin n_bad++; $display("FAIL rw_new_data: got %h expected 5555", rd); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd;
    logic er;
    int lt;
    do_req(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0777, rd, er, lt);
    do_req(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h00FF, rd, er, lt);
    do_req(1'b0, 1'b1, 1'b1, 16'h003F, 16'h3F3F, rd, er, lt);
    do_req(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, rd, er, lt);
    n_cmp++;
    if (er !== 1'b1) begin n_bad++; $display("FAIL stk_oor_error: got %b expected 1", er); end
    n_cmp++;
    if (rd !== 16'h0000) begin n_bad++; $display("FAIL stk_oor_rdata: got %h expected 0000", rd); end
    do_req(1'b0, 1'b1, 1'b0, 16'h0100, 16'hDEAD, rd, er, lt);
    n_cmp++;
    if (er !== 1'b1) begin n_bad++; $display("FAIL data_oor_error: got %b expected 1", er); end
    do_req(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, rd, er, lt);
    n_cmp++;
    if (rd !== 16'h0777) begin n_bad++; $display("FAIL no_wrap: got %h expected 0777", rd); end
    n_cmp++;
    if (er !== 1'b0) begin n_bad++; $display("FAIL inrange_error: got %b expected 0", er); end
    do_req(1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000, rd, er, lt);
    n_cmp++;
    if (rd !== 16'h00FF || er !== 1'b0) begin
      n_bad++; $display("FAIL data_top_addr: got %h/%b expected 00ff/0", rd, er);
    end
    do_req(1'b1, 1'b0, 1'b1, 16'h003F, 16'h0000, rd, er, lt);
    n_cmp++;
    if (rd !== 16'h3F3F || er !== 1'b0) begin
      n_bad++; $display("FAIL stk_top_addr: got %h/%b expected 3f3f/0", rd, er);
    end
  endtask

  task automatic test_no_op();
    int rsp;
    rsp = 0;
    @(negedge clock);
    req_valid = 1'b1;
    req_read  = 1'b0;
    req_write = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (resp_valid) rsp++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL noop_ready: got %b expected 1", req_ready); end
    n_cmp++;
    if (rsp !== 0) begin n_bad++; $display("FAIL noop_resp: got %0d expected 0", rsp); end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [15:0] rd;
    logic er;
    int lt;
    int rsp;
    rsp = 0;
    do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0001, rd, er, lt);
    do_req(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, rd, er, lt);
    @(negedge clock);
    req_valid = 1'b1;
    req_read  = 1'b0;
    req_write = 1'b1;
    req_stack = 1'b0;
    req_addr  = 16'h0010;
    req_wdata = 16'hFFFF;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 16'h0000 || resp_error !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: ready=%b valid=%b rdata=%h err=%b expected 0/0/0000/0",
               req_ready, resp_valid, resp_rdata, resp_error);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (resp_valid) rsp++;
    end
    n_cmp++;
    if (rsp !== 0) begin n_bad++; $display("FAIL abort_resp: got %0d expected 0", rsp); end
    do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, er, lt);
    n_cmp++;
    if (rd !== 16'h0001) begin n_bad++; $display("FAIL abort_no_write: got %h expected 0001", rd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd;
    logic er;
    int lt;
    int acc;
    int rsp;
    acc = 0;
    rsp = 0;
    do_req(1'b0, 1'b1, 1'b1, 16'h0021, 16'h1111, rd, er, lt);
    @(negedge clock);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clock);
      req_valid = 1'b1;
      req_read  = 1'b0;
      req_write = 1'b1;
      req_stack = 1'b1;
      req_addr  = 16'h0020 + 16'(k);
      req_wdata = 16'hA000 + 16'(k);
      if (req_ready) acc++;
      if (resp_valid) rsp++;
    end
    @(negedge clock);
    req_valid = 1'b0;
    repeat (4) begin
      if (resp_valid) rsp++;
      @(negedge clock);
    end
    n_cmp++;
    if (acc !== 4) begin n_bad++; $display("FAIL b2b_accepts: got %0d expected 4", acc); end
    n_cmp++;
    if (rsp !== 4) begin n_bad++; $display("FAIL b2b_resps: got %0d expected 4", rsp); end
    do_req(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, rd, er, lt);
    n_cmp++;
    if (rd !== 16'hA000) begin n_bad++; $display("FAIL b2b_addr20: got %h expected a000", rd); end
    do_req(1'b1, 1'b0, 1'b1, 16'h0021, 16'h0000, rd, er, lt);
    n_cmp++;
    if (rd !== 16'h1111) begin n_bad++; $display("FAIL b2b_addr21: got %h expected 1111", rd); end
    do_req(1'b1, 1'b0, 1'b1, 16'h0029, 16'h0000, rd, er, lt);
    n_cmp++;
    if (rd !== 16'hA009) begin n_bad++; $display("FAIL b2b_addr29: got %h expected a009", rd); end
  endtask

  initial begin
    test_reset();
    test_data_rw();
    test_spaces();
    test_read_write();
    test_out_of_range();
    test_no_op();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stack_responder.md
MEM_STACK_RESPONDER -- requirements
Module: mem_stack_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 16-bit words in data memory.
REQ-002 SHALL have parameter STK_DEPTH, default 64, number of 16-bit words in stack memory.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_read  input  1  request reads word at req_addr.
REQ-007 SHALL have port req_write  input  1  request writes req_wdata to req_addr.
REQ-008 SHALL have port req_stack  input  1  target space: 0 = data memory, 1 = stack memory.
REQ-009 SHALL have port req_addr  input  16  word address in selected space.
REQ-010 SHALL have port req_wdata  input  16  write data.
REQ-011 SHALL have port req_ready  output  1  responder idle, request accepted this edge if valid.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  16  read result.
REQ-014 SHALL have port resp_error  output  1  address out of range; qualified by resp_valid.

Function
REQ-015 SHALL implement states IDLE, RD, WR, DONE; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with state IDLE, req_valid = 1, and (req_read | req_write) = 1; it SHALL capture req_addr, req_wdata, req_read, req_write, req_stack at that edge.
REQ-017 SHALL ignore req_valid = 1 with req_read = req_write = 0 (stays IDLE, no response).
REQ-018 SHALL transition IDLE -> RD on accept if req_read = 1, else IDLE -> WR.
REQ-019 SHALL, at the RD exit edge, load resp_rdata from the selected space at captured address, then go to WR if captured write = 1, else DONE.
REQ-020 SHALL, at the WR exit edge, write captured wdata to the selected space, then go to DONE.
REQ-021 SHALL drive resp_valid = 1 exactly for the single DONE cycle; DONE -> IDLE unconditionally.
REQ-022 SHALL give latency accept-edge to resp_valid high: 2 edges for read-only or write-only, 3 edges for read+write; minimum request spacing 3 edges (read-only/write-only) or 4 (read+write).
REQ-023 SHALL perform read before write for a read+write request; resp_rdata returns the pre-write contents.
REQ-024 SHALL treat address >= MEM_DEPTH (data) or >= STK_DEPTH (stack) as out of range: no wrap, write suppressed, resp_rdata loaded with 16'h0000, resp_error = 1 in DONE.
REQ-025 SHALL keep data and stack spaces independent; same address in different spaces never aliases.
REQ-026 SHALL hold resp_rdata between RD states; write-only requests leave it unchanged.
REQ-027 SHALL ignore all req_* inputs outside IDLE.

Reset
REQ-028 SHALL, while reset = 1, force state IDLE, req_ready = 0, resp_valid = 0, resp_rdata = 16'h0000, resp_error = 0, independent of clock.
REQ-029 SHALL drive req_ready = 1 from the first cycle after reset deasserts.
REQ-030 SHALL abandon any in-flight request on reset; a write whose WR exit edge has not occurred SHALL NOT modify memory.
REQ-031 SHALL NOT clear memory contents on reset.

Verification
REQ-032 Write-only data addr 0x0005 = 0xBEEF, then read-only addr 0x0005 -> second resp_valid 2 edges after accept, resp_rdata = 0xBEEF, resp_error = 0.
REQ-033 Stack write addr 0x0005 = 0x1234 after REQ-032 -> data read addr 0x0005 still 0xBEEF, stack read 0x1234.
REQ-034 Read+write stack addr 0x0003 (old 0x00AA, wdata 0x5555) -> resp_valid 3 edges after accept, resp_rdata = 0x00AA; subsequent read returns 0x5555.
REQ-035 Stack read addr 0x0040 (= STK_DEPTH) and data write addr 0x0100 -> resp_error = 1, resp_rdata = 0x0000, data addr 0x0000 unchanged (no wrap).
REQ-036 Accept write data addr 0x0010 = 0xFFFF (old 0x0001), assert reset before WR exit edge -> outputs reset immediately, no resp_valid, later read of 0x0010 = 0x0001.
REQ-037 Hold req_valid = 1 continuously with new operands during RD/WR/DONE -> only IDLE-cycle requests accepted; exactly one resp_valid per accept.
